to_lower_stream: RTL

Streaming ASCII lowercase converter with the same character mapping rules as the existing combinational uppercase converter, in the opposite direction. It accepts one byte per cycle on a valid/ready input stream and maps 'A'–'Z' (65–90) to 'a'–'z' (97–122). All other codes, including 128–255, pass through unchanged. It sits between a byte source and sink in the text path and has a 2-entry elastic buffer, so both the input and the output side see registered handshake signals.

---
 rtl/to_lower_stream.sv | 98 +++++++++
 1 files changed

// File: rtl/to_lower_stream.sv
// Streaming ASCII lowercase converter with a 2-entry elastic buffer.
// Optional statistics counters are enabled with the TO_LOWER_STATS_EN macro.
module to_lower_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] conv_count,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] head;
    logic [7:0] tail;
    logic [7:0] mapped;
    logic       is_upper;
    logic       push;
    logic       pop;

    // Handshakes come straight from the state register, so neither side
    // sees a combinational path from the other.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        is_upper = conv_en && (in_data >= 8'd65) && (in_data <= 8'd90);
        mapped   = is_upper ? (in_data + 8'd32) : in_data;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // head always holds the oldest entry; tail is only used while FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= 8'h00;
            tail <= 8'h00;
        end else begin
            case (state)
                EMPTY: if (push) head <= mapped;
                ONE: begin
                    if (push && pop) head <= mapped;
                    else if (push)   tail <= mapped;
                end
                FULL:    if (pop) head <= tail;
                default: ;
            endcase
        end
    end

`ifdef TO_LOWER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= '0;
            conv_count <= '0;
        end else if (push) begin
            if (byte_count != {CNT_W{1'b1}}) byte_count <= byte_count + 1'b1;
            if (is_upper && (conv_count != {CNT_W{1'b1}})) conv_count <= conv_count + 1'b1;
        end
    end
`else
    assign byte_count = '0;
    assign conv_count = '0;
`endif

endmodule
